counter_ctrl: RTL and testbench



---
 rtl/counter_ctrl_pkg.sv | 14 +
 rtl/counter_ctrl_prescaler.sv | 35 +++
 rtl/counter_ctrl.sv | 111 +++++++++++
 tb/tb_counter_ctrl.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/counter_ctrl_pkg.sv
// Shared types and default sizes for the counter run controller.
package counter_ctrl_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StClear,
    StRun,
    StDone
  } state_e;

  localparam int unsigned DefWidth = 4;
  localparam int unsigned DefPreW  = 4;

endpackage

// File: rtl/counter_ctrl_prescaler.sv
// Enable divider: one tick per (div+1) RUN cycles not under hold.
module counter_ctrl_prescaler #(
  parameter int unsigned PRE_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             run,
  input  logic             hold,
  input  logic [PRE_W-1:0] div,
  output logic             tick
);

  logic [PRE_W-1:0] cnt_q, cnt_d;

  assign tick = run & ~hold & (cnt_q == div);

  always_comb begin
    cnt_d = cnt_q;
    if (clear || tick) begin
      cnt_d = '0;
    end else if (run && !hold) begin
      cnt_d = cnt_q + PRE_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/counter_ctrl.sv
// Run controller for an external counter: clear, count to target, pulse done.
// Optional enable prescaler is built when COUNTER_CTRL_PRESCALE_EN is defined.
module counter_ctrl
  import counter_ctrl_pkg::*;
#(
  parameter int unsigned WIDTH = DefWidth,
  parameter int unsigned PRE_W = DefPreW
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  input  logic             hold,
  input  logic [WIDTH-1:0] target,
  input  logic [PRE_W-1:0] prescale,
  input  logic [WIDTH-1:0] count,
  output logic             cnt_en,
  output logic             cnt_rst,
  output logic             busy,
  output logic             done
);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] target_q;
  logic             accept;
  logic             at_target;
  logic             tick;
  logic             in_clear;
  logic             in_run;

  assign accept    = (state_q == StIdle) & start & ~abort;
  assign at_target = (count == target_q);
  assign in_clear  = (state_q == StClear);
  assign in_run    = (state_q == StRun);

`ifdef COUNTER_CTRL_PRESCALE_EN
  logic [PRE_W-1:0] prescale_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      prescale_q <= '0;
    end else if (accept) begin
      prescale_q <= prescale;
    end
  end

  counter_ctrl_prescaler #(
    .PRE_W(PRE_W)
  ) u_prescaler (
    .clk  (clk),
    .rst  (rst),
    .clear(in_clear),
    .run  (in_run),
    .hold (hold),
    .div  (prescale_q),
    .tick (tick)
  );
`else
  logic unused_prescale;
  assign unused_prescale = ^prescale;
  assign tick            = 1'b1;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StIdle;
      target_q <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        target_q <= target;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_en  = 1'b0;
    cnt_rst = 1'b0;
    busy    = 1'b0;
    done    = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (accept) begin
          state_d = StClear;
        end
      end
      StClear: begin
        cnt_rst = 1'b1;
        busy    = 1'b1;
        state_d = abort ? StIdle : StRun;
      end
      StRun: begin
        busy = 1'b1;
        // Gated on live count so the counter never steps past the target.
        cnt_en = tick & ~hold & ~abort & ~at_target;
        if (abort) begin
          state_d = StIdle;
        end else if (!hold && at_target) begin
          state_d = StDone;
        end
      end
      StDone: begin
        done    = ~abort;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

endmodule

// File: tb/tb_counter_ctrl.sv
// Self-checking bench for counter_ctrl with a behavioural counter and reference model.
module tb_counter_ctrl;

  localparam int PIdle  = 0;
  localparam int PClear = 1;
  localparam int PRun   = 2;
  localparam int PDone  = 3;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic       abort = 1'b0;
  logic       hold = 1'b0;
  logic [3:0] target = 4'd0;
  logic [3:0] prescale = 4'd0;
  logic [3:0] count = 4'd0;
  logic       cnt_en, cnt_rst, busy, done;

  int n_checks = 0;
  int n_err    = 0;
  int cyc      = 0;
  bit mon_on   = 1'b0;

  // Reference model state
  int         m_ph  = PIdle;
  logic [3:0] m_tgt = 4'd0;
  int         m_div = 0;
  int         m_pc  = 0;
  logic [3:0] m_count = 4'd0;
  logic       exp_busy, exp_done, exp_rst, exp_en;

  // Per-scenario statistics
  int en_cnt, rst_cnt, done_cnt, done_cyc, start_edge, last_en, gmin, gmax;

  counter_ctrl dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .abort   (abort),
    .hold    (hold),
    .target  (target),
    .prescale(prescale),
    .count   (count),
    .cnt_en  (cnt_en),
    .cnt_rst (cnt_rst),
    .busy    (busy),
    .done    (done)
  );

  always #5 clk = ~clk;

  // Counter instance stand-in: synchronous clear, increment on enable.
  always @(posedge clk) begin
    if (cnt_rst) count <= 4'd0;
    else if (cnt_en) count <= count + 4'd1;
    cyc <= cyc + 1;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (mon_on) begin
      exp_busy = (m_ph == PClear) || (m_ph == PRun);
      exp_done = (m_ph == PDone) && !abort;
      exp_rst  = (m_ph == PClear);
      exp_en   = (m_ph == PRun) && !hold && !abort && (count != m_tgt) && (m_pc == m_div);
      check("busy", busy, exp_busy);
      check("done", done, exp_done);
      check("cnt_rst", cnt_rst, exp_rst);
      check("cnt_en", cnt_en, exp_en);
      check("count", count, m_count);

      if (cnt_en) begin
        en_cnt++;
        if (last_en >= 0) begin
          if (cyc - last_en < gmin) gmin = cyc - last_en;
          if (cyc - last_en > gmax) gmax = cyc - last_en;
        end
        last_en = cyc;
      end
      if (cnt_rst) rst_cnt++;
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
      end

      if (exp_rst) m_count = 4'd0;
      else if (exp_en) m_count = m_count + 4'd1;

      if (rst) begin
        m_ph = PIdle; m_tgt = 4'd0; m_div = 0; m_pc = 0;
      end else begin
        case (m_ph)
          PIdle: if (start && !abort) begin
            m_tgt = target;
`ifdef COUNTER_CTRL_PRESCALE_EN
            m_div = int'(prescale);
`else
            m_div = 0;
`endif
            m_ph = PClear;
          end
          PClear: begin
            m_pc = 0;
            m_ph = abort ? PIdle : PRun;
          end
          PRun: begin
            if (!hold) m_pc = (m_pc == m_div) ? 0 : m_pc + 1;
            if (abort) m_ph = PIdle;
            else if (!hold && count == m_tgt) m_ph = PDone;
          end
          default: m_ph = PIdle;
        endcase
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_stats();
    en_cnt = 0; rst_cnt = 0; done_cnt = 0; done_cyc = -1;
    last_en = -1; gmin = 1000; gmax = 0;
  endtask

  task automatic do_start(input int t, input int p);
    clear_stats();
    target     = 4'(t);
    prescale   = 4'(p);
    start      = 1'b1;
    start_edge = cyc + 1;
    step();
    start = 1'b0;
  endtask

  task automatic wait_done(input int bound);
    int n = 0;
    while (done_cnt == 0 && n < bound) begin
      step();
      n++;
    end
    check("done_seen", done_cnt != 0, 1);
  endtask

  task automatic wait_count(input int v, input int bound);
    int n = 0;
    while (count != 4'(v) && n < bound) begin
      step();
      n++;
    end
    check("count_reached", count, v);
  endtask

  task automatic run_case(input string nm, input int t, input int p, input int exp_lat);
    do_start(t, p);
    wait_done(200);
    step();
    step();
    check({nm, "_en_pulses"}, en_cnt, t);
    check({nm, "_rst_pulses"}, rst_cnt, 1);
    check({nm, "_done_pulses"}, done_cnt, 1);
    check({nm, "_latency"}, done_cyc - start_edge, exp_lat);
    check({nm, "_final_count"}, count, t);
    check({nm, "_busy_after"}, busy, 0);
  endtask

  initial begin
    clear_stats();
    step();
    step();
    mon_on = 1'b1;
    check("reset_cnt_en", cnt_en, 0);
    check("reset_cnt_rst", cnt_rst, 0);
    check("reset_busy", busy, 0);
    check("reset_done", done, 0);
    rst = 1'b0;
    step();

    run_case("t5", 5, 0, 7);
    run_case("t0", 0, 0, 2);

`ifdef COUNTER_CTRL_PRESCALE_EN
    run_case("t15p2", 15, 2, 47);
    check("t15p2_gap_min", gmin, 3);
    check("t15p2_gap_max", gmax, 3);
`else
    run_case("t15p2", 15, 2, 17);
    check("t15p2_gap_min", gmin, 1);
    check("t15p2_gap_max", gmax, 1);
`endif

    // Hold for four cycles once the count reaches 3.
    do_start(8, 0);
    wait_count(3, 50);
    hold = 1'b1;
    repeat (4) step();
    check("hold_count_frozen", count, 3);
    hold = 1'b0;
    wait_done(100);
    step();
    check("hold_en_pulses", en_cnt, 8);
    check("hold_latency", done_cyc - start_edge, 14);
    check("hold_final_count", count, 8);

    // Abort at count 6 with a spurious start during the run.
    do_start(10, 0);
    wait_count(2, 50);
    start  = 1'b1;
    target = 4'd3;
    step();
    start = 1'b0;
    wait_count(6, 50);
    abort = 1'b1;
    @(negedge clk);
    check("abort_en_same_cycle", cnt_en, 0);
    check("abort_busy_same_cycle", busy, 1);
    step();
    abort = 1'b0;
    check("abort_busy_next", busy, 0);
    repeat (3) step();
    check("abort_count_held", count, 6);
    check("abort_no_done", done_cnt, 0);

    // Synchronous reset mid-run, then a fresh run.
    do_start(9, 0);
    wait_count(4, 50);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("rst_cnt_en", cnt_en, 0);
    check("rst_cnt_rst", cnt_rst, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_no_done", done_cnt, 0);
    run_case("t2_after_rst", 2, 0, 4);

    // Randomized traffic checked cycle by cycle against the model.
    for (int i = 0; i < 600; i++) begin
      rst      = ($urandom_range(0, 79) == 0);
      start    = ($urandom_range(0, 7) == 0);
      abort    = ($urandom_range(0, 39) == 0);
      hold     = ($urandom_range(0, 5) == 0);
      target   = 4'($urandom_range(0, 15));
      prescale = 4'($urandom_range(0, 3));
      step();
    end
    rst = 1'b0; start = 1'b0; abort = 1'b0; hold = 1'b0;
    repeat (5) step();

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
